tge_tx_packetizer: RTL and testbench

- Sits directly upstream of the 10GbE core's application TX port. Accepts a 64-bit word stream using a valid/ready handshake.
- Slices the stream into fixed-length UDP payloads. Optionally prepends a 64-bit sequence header and drives tx_valid / tx_end_of_frame / tx_dest_ip / tx_dest_port.
- If the core reports almost-full at a packet boundary, the whole packet is dropped rather than truncated. Packet, drop and overflow statistics are kept.

---
 rtl/tge_pkg.sv | 27 ++
 rtl/tge_sat_counter.sv | 23 ++
 rtl/tge_tx_packetizer.sv | 155 +++++++++++++++
 tb/tb_tge_tx_packetizer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tge_pkg.sv
// Shared types for the 10GbE TX packetizer: FSM states, header layout and packing.
package tge_pkg;

  localparam int SEQ_W = 48;
  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [LEN_W-1:0] len;
  } hdr_t;

  function automatic logic [63:0] pack_hdr(input logic [SEQ_W-1:0] seq,
                                           input logic [LEN_W-1:0] len);
    hdr_t h;
    h.seq = seq;
    h.len = len;
    return h;
  endfunction

endpackage

// File: rtl/tge_sat_counter.sv
// Saturating event counter; updates one cycle after inc, sticks at all-ones.
// No backpressure; clr wins over a simultaneous inc.
module tge_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tge_tx_packetizer.sv
// Slices a 64-bit word stream into fixed-length UDP frames; one-cycle registered latency.
// Upstream is stalled while idle or sending the header; whole packets drop on afull at start.
module tge_tx_packetizer
  import tge_pkg::*;
#(
  parameter int PAYLOAD_WORDS = 128,
  parameter bit HEADER_EN     = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cnt_clr,
  input  logic [31:0]      cfg_dest_ip,
  input  logic [15:0]      cfg_dest_port,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             in_ready,
  output logic             tx_valid,
  output logic             tx_end_of_frame,
  output logic [63:0]      tx_data,
  output logic [31:0]      tx_dest_ip,
  output logic [15:0]      tx_dest_port,
  input  logic             tx_afull,
  input  logic             tx_overflow,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] overflow_count,
  output logic             busy
);

  localparam int          CW   = $clog2(PAYLOAD_WORDS);
  localparam logic [CW-1:0] LAST = CW'(PAYLOAD_WORDS - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    wcnt, wcnt_nxt;
  logic [SEQ_W-1:0] seq_num, seq_nxt;
  logic             in_ready_nxt, tx_valid_nxt, tx_eof_nxt;
  logic [63:0]      tx_data_nxt;
  logic [31:0]      ip_nxt;
  logic [15:0]      port_nxt;
  logic             pkt_inc, drop_inc;
  logic             accept;

  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wcnt            <= '0;
      seq_num         <= '0;
      in_ready        <= 1'b0;
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;
      tx_data         <= '0;
      tx_dest_ip      <= '0;
      tx_dest_port    <= '0;
    end else begin
      state           <= state_nxt;
      wcnt            <= wcnt_nxt;
      seq_num         <= seq_nxt;
      in_ready        <= in_ready_nxt;
      tx_valid        <= tx_valid_nxt;
      tx_end_of_frame <= tx_eof_nxt;
      tx_data         <= tx_data_nxt;
      tx_dest_ip      <= ip_nxt;
      tx_dest_port    <= port_nxt;
    end
  end

  // Outputs are computed from the next state so in_ready drops on the same
  // edge that registers the last word, and no extra word slips in.
  always_comb begin
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    seq_nxt      = seq_num;
    in_ready_nxt = 1'b0;
    tx_valid_nxt = 1'b0;
    tx_eof_nxt   = 1'b0;
    tx_data_nxt  = tx_data;
    ip_nxt       = tx_dest_ip;
    port_nxt     = tx_dest_port;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (en && in_valid) begin
          ip_nxt   = cfg_dest_ip;
          port_nxt = cfg_dest_port;
          if (tx_afull) begin
            state_nxt    = DROP;
            in_ready_nxt = 1'b1;
          end else if (HEADER_EN) begin
            state_nxt    = HDR;
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = pack_hdr(seq_num, LEN_W'(PAYLOAD_WORDS));
          end else begin
            state_nxt    = PAYLOAD;
            in_ready_nxt = 1'b1;
          end
        end
      end
      HDR: begin
        state_nxt    = PAYLOAD;
        in_ready_nxt = 1'b1;
      end
      PAYLOAD: begin
        in_ready_nxt = 1'b1;
        if (accept) begin
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = in_data;
          if (wcnt == LAST) begin
            tx_eof_nxt   = 1'b1;
            in_ready_nxt = 1'b0;
            wcnt_nxt     = '0;
            seq_nxt      = seq_num + 1'b1;
            pkt_inc      = 1'b1;
            state_nxt    = IDLE;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end
      DROP: begin
        in_ready_nxt = 1'b1;
        if (accept) begin
          if (wcnt == LAST) begin
            in_ready_nxt = 1'b0;
            wcnt_nxt     = '0;
            seq_nxt      = seq_num + 1'b1;
            drop_inc     = 1'b1;
            state_nxt    = IDLE;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  tge_sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .clk(clk), .rst_n(rst_n), .inc(pkt_inc), .clr(cnt_clr), .count(pkt_count)
  );

  tge_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .inc(drop_inc), .clr(cnt_clr), .count(drop_count)
  );

  tge_sat_counter #(.W(CNT_W)) u_ovf_cnt (
    .clk(clk), .rst_n(rst_n), .inc(tx_overflow), .clr(cnt_clr), .count(overflow_count)
  );

endmodule

// File: tb/tb_tge_tx_packetizer.sv
// Bench for tge_tx_packetizer: packet-level reference model compared every cycle, plus pinned literals.
module tb_tge_tx_packetizer;

  localparam int PW    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk, rst_n, en, cnt_clr;
  logic [31:0]      cfg_dest_ip;
  logic [15:0]      cfg_dest_port;
  logic             in_valid, in_ready;
  logic [63:0]      in_data;
  logic             tx_valid, tx_end_of_frame;
  logic [63:0]      tx_data;
  logic [31:0]      tx_dest_ip;
  logic [15:0]      tx_dest_port;
  logic             tx_afull, tx_overflow;
  logic [CNT_W-1:0] pkt_count, drop_count, overflow_count;
  logic             busy;

  tge_tx_packetizer #(.PAYLOAD_WORDS(PW), .HEADER_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cnt_clr(cnt_clr),
    .cfg_dest_ip(cfg_dest_ip), .cfg_dest_port(cfg_dest_port),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_valid(tx_valid), .tx_end_of_frame(tx_end_of_frame), .tx_data(tx_data),
    .tx_dest_ip(tx_dest_ip), .tx_dest_port(tx_dest_port),
    .tx_afull(tx_afull), .tx_overflow(tx_overflow),
    .pkt_count(pkt_count), .drop_count(drop_count), .overflow_count(overflow_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: a packet in progress is "words_left" words long, optionally
  // preceded by a pending header beat; discarding marks a dropped packet.
  int          words_left;
  bit          hdr_pending, discarding;
  bit          exp_ready, exp_valid, exp_eof;
  logic [63:0] m_data;
  logic [47:0] m_seq;
  logic [31:0] m_ip;
  logic [15:0] m_port;
  int          m_pkt, m_drop, m_ovf;

  logic [63:0] hdrs[$];
  logic [31:0] eof_ips[$];
  bit          in_frame;
  int          nbeat, neof;

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    words_left = 0; hdr_pending = 0; discarding = 0;
    exp_ready = 0; exp_valid = 0; exp_eof = 0;
    m_data = '0; m_seq = '0; m_ip = '0; m_port = '0;
    m_pkt = 0; m_drop = 0; m_ovf = 0;
    in_frame = 0;
  endtask

  task automatic model_step();
    bit acc;
    acc = in_valid && exp_ready;
    exp_valid = 0;
    exp_eof   = 0;
    if (words_left == 0 && !hdr_pending) begin
      if (en && in_valid) begin
        m_ip = cfg_dest_ip;
        m_port = cfg_dest_port;
        words_left = PW;
        discarding = tx_afull;
        if (tx_afull) begin
          exp_ready = 1;
        end else begin
          hdr_pending = 1;
          exp_valid = 1;
          m_data = {m_seq, 16'(PW)};
        end
      end
    end else if (hdr_pending) begin
      hdr_pending = 0;
      exp_ready = 1;
    end else if (acc) begin
      words_left--;
      if (!discarding) begin
        exp_valid = 1;
        m_data = in_data;
      end
      if (words_left == 0) begin
        exp_ready = 0;
        m_seq = m_seq + 48'd1;
        if (discarding) m_drop = sat(m_drop);
        else begin
          exp_eof = 1;
          m_pkt = sat(m_pkt);
        end
      end
    end
    if (tx_overflow) m_ovf = sat(m_ovf);
    if (cnt_clr) begin
      m_pkt = 0; m_drop = 0; m_ovf = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("tx_valid", 64'(tx_valid), 64'(exp_valid));
    chk("tx_eof", 64'(tx_end_of_frame), 64'(exp_eof));
    chk("busy", 64'(busy), 64'(words_left != 0 || hdr_pending));
    chk("tx_data", tx_data, m_data);
    chk("tx_dest_ip", 64'(tx_dest_ip), 64'(m_ip));
    chk("tx_dest_port", 64'(tx_dest_port), 64'(m_port));
    chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("overflow_count", 64'(overflow_count), 64'(m_ovf));
    if (tx_valid) begin
      nbeat++;
      if (!in_frame) begin
        hdrs.push_back(tx_data);
        in_frame = 1;
      end
      if (tx_end_of_frame) begin
        neof++;
        eof_ips.push_back(tx_dest_ip);
        in_frame = 0;
      end
    end
  endtask

  task automatic cyc(input bit e, input bit v, input bit af, input logic [31:0] ip,
                     input logic [15:0] port, input bit ovf, input bit clr);
    en = e; in_valid = v; tx_afull = af;
    cfg_dest_ip = ip; cfg_dest_port = port;
    tx_overflow = ovf; cnt_clr = clr;
    in_data = {$urandom, $urandom};
    model_step();
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_tx_eof"}, 64'(tx_end_of_frame), 64'd0);
    chk({tag, "_tx_data"}, tx_data, 64'd0);
    chk({tag, "_tx_dest_ip"}, 64'(tx_dest_ip), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
    chk({tag, "_overflow_count"}, 64'(overflow_count), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    en = 0; in_valid = 0; tx_afull = 0; tx_overflow = 0; cnt_clr = 0;
    #1;
    check_zero(tag);
    model_reset();
    hdrs.delete();
    eof_ips.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic bound_fail(input string name, input bit done);
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: got timeout expected completion", name);
    end
  endtask

  bit changed;
  int mid_bound;

  initial begin
    rst_n = 1'b1;
    en = 0; in_valid = 0; in_data = '0; tx_afull = 0; tx_overflow = 0; cnt_clr = 0;
    cfg_dest_ip = 32'h0A000001; cfg_dest_port = 16'd5000;
    model_reset();
    #1;
    do_reset("rst0");

    // Four back-to-back packets.
    nbeat = 0; neof = 0;
    for (int c = 0; c < 200 && m_pkt < 4; c++) cyc(1, 1, 0, 32'h0A000001, 16'd5000, 0, 0);
    bound_fail("A_done", m_pkt == 4);
    chk("A_pkt_count", 64'(pkt_count), 64'd4);
    chk("A_beats", 64'(nbeat), 64'd20);
    chk("A_eofs", 64'(neof), 64'd4);
    chk("A_nhdr", 64'(hdrs.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("A_hdr", hdrs[i], 64'(i * 65536 + 4));

    // Second packet dropped on afull at its start.
    do_reset("rstB");
    nbeat = 0; neof = 0;
    for (int c = 0; c < 200 && m_seq < 4; c++)
      cyc(1, 1, (words_left == 0 && !hdr_pending && m_seq == 48'd1), 32'h0A000001, 16'd5000, 0, 0);
    bound_fail("B_done", m_seq == 4);
    chk("B_drop_count", 64'(drop_count), 64'd1);
    chk("B_pkt_count", 64'(pkt_count), 64'd3);
    chk("B_nhdr", 64'(hdrs.size()), 64'd3);
    chk("B_hdr0", hdrs[0], 64'h0000_0000_0000_0004);
    chk("B_hdr1", hdrs[1], 64'h0000_0000_0002_0004);
    chk("B_hdr2", hdrs[2], 64'h0000_0000_0003_0004);

    // Alternating in_valid during payload.
    nbeat = 0; neof = 0;
    for (int c = 0; c < 200 && m_seq < 6; c++) cyc(1, c[0] == 1'b0, 0, 32'h0A000001, 16'd5000, 0, 0);
    bound_fail("C_done", m_seq == 6);
    chk("C_beats", 64'(nbeat), 64'd10);
    chk("C_eofs", 64'(neof), 64'd2);

    // Destination change in mid-frame applies to the next frame only.
    eof_ips.delete();
    changed = 0;
    for (int c = 0; c < 200 && m_seq < 8; c++) begin
      if (words_left == 2 && !hdr_pending) changed = 1;
      cyc(1, 1, 0, changed ? 32'h0A000002 : 32'h0A000001, 16'd5000, 0, 0);
    end
    bound_fail("D_done", m_seq == 8);
    chk("D_neof", 64'(eof_ips.size()), 64'd2);
    chk("D_ip0", 64'(eof_ips[0]), 64'h0A000001);
    chk("D_ip1", 64'(eof_ips[1]), 64'h0A000002);

    // en dropped mid-packet: packet completes, then stays idle.
    neof = 0;
    mid_bound = 0;
    while (mid_bound < 50 && !(words_left == 2 && !hdr_pending)) begin
      cyc(1, 1, 0, 32'h0A000003, 16'd6000, 0, 0);
      mid_bound++;
    end
    bound_fail("E_mid", words_left == 2);
    for (int c = 0; c < 15; c++) cyc(0, 1, 0, 32'h0A000003, 16'd6000, 0, 0);
    chk("E_eof", 64'(neof), 64'd1);
    chk("E_busy", 64'(busy), 64'd0);
    chk("E_tx_valid", 64'(tx_valid), 64'd0);

    // Overflow pulse with clear on the third cycle, then saturation.
    cyc(0, 0, 0, 32'h0, 16'h0, 1, 0);
    cyc(0, 0, 0, 32'h0, 16'h0, 1, 0);
    cyc(0, 0, 0, 32'h0, 16'h0, 1, 1);
    cyc(0, 0, 0, 32'h0, 16'h0, 0, 0);
    chk("E_ovf_clr", 64'(overflow_count), 64'd0);
    chk("E_pkt_clr", 64'(pkt_count), 64'd0);
    for (int c = 0; c < 20; c++) cyc(0, 0, 0, 32'h0, 16'h0, 1, 0);
    chk("E_ovf_sat", 64'(overflow_count), 64'(CMAX));

    // Randomized traffic.
    for (int c = 0; c < 1500; c++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
          $urandom, 16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);

    // Asynchronous reset in the middle of a frame.
    mid_bound = 0;
    while (mid_bound < 60 && !(words_left == 2 && !hdr_pending && !discarding)) begin
      cyc(1, 1, 0, 32'h0A000004, 16'd7000, 0, 0);
      mid_bound++;
    end
    bound_fail("G_mid", words_left == 2);
    #2;
    do_reset("rstG");
    for (int c = 0; c < 20 && hdrs.size() == 0; c++) cyc(1, 1, 0, 32'h0A000004, 16'd7000, 0, 0);
    chk("G_nhdr", 64'(hdrs.size()), 64'd1);
    chk("G_hdr", hdrs[0], 64'h0000_0000_0000_0004);
    for (int c = 0; c < 10; c++) cyc(1, 1, 0, 32'h0A000004, 16'd7000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
